// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// A column/line counter pair walks the full raster (active + porches + sync)
// on every cycle where en is high. From the counter position it decodes sync
// and visibility, and passes hsync/vsync/sync_b/blank_b through a
// PIPE_DELAY-deep enable-gated delay line. The delay keeps those outputs
// aligned with a downstream pixel lookup pipeline of the same depth.
//
// Ports:
//   clk         clock (pixel clock, or faster with en as pixel enable)
//   reset       asynchronous active-low reset
//   en          pixel advance enable
//   x, y        current column / line (undelayed)
//   active      current position is inside the visible area (undelayed)
//   line_start  strobe on an enabled cycle at column 0
//   frame_start strobe on an enabled cycle at column 0, line 0
//   hsync       horizontal sync at HSYNC_POL level when asserted (delayed)
//   vsync       vertical sync at VSYNC_POL level when asserted (delayed)
//   sync_b      composite sync, active-low (delayed)
//   blank_b     active-low blank, 1 = visible (delayed)
//   frame_cnt   completed-frame count, wraps
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int PIPE_DELAY = 2,
    parameter int CW         = 10,
    parameter int FCW        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           active,
    output logic           line_start,
    output logic           frame_start,
    output logic           hsync,
    output logic           vsync,
    output logic           sync_b,
    output logic           blank_b,
    output logic [FCW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    generate
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_geom
            $error("vga_timing_gen: active/porch/sync parameters must all be non-zero");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be in 0..8");
        end
        if (CW < 1 || CW > 31 || longint'(MAX_TOTAL) > (longint'(1) << CW)) begin : g_bad_cw
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
        if (FCW < 1) begin : g_bad_fcw
            $error("vga_timing_gen: FCW must be at least 1");
        end
    endgenerate

    // Decode thresholds sized to the counters so every compare is CW wide.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HP       = (HSYNC_POL != 0);
    localparam logic          VP       = (VSYNC_POL != 0);

    // Delay-line word: {hsync, vsync, sync_b, blank_b}.
    localparam logic [3:0]    IDLE     = {~HP, ~VP, 1'b1, 1'b0};

    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic [FCW-1:0] fc_q, fc_d;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fc_d = fc_q + 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q  <= '0;
            y_q  <= '0;
            fc_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fc_q <= fc_d;
        end
    end

    logic hs_act, vs_act, vis;
    logic [3:0] raw, dly_out;

    assign hs_act = (x_q >= HS_BEG) && (x_q < HS_END);
    assign vs_act = (y_q >= VS_BEG) && (y_q < VS_END);
    assign vis    = (x_q < H_VIS) && (y_q < V_VIS);
    assign raw    = {hs_act ? HP : ~HP,
                     vs_act ? VP : ~VP,
                     ~(hs_act | vs_act),
                     vis};

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign dly_out = raw;
        end else begin : g_dly
            logic [3:0] dly_q [PIPE_DELAY];

            // Stages start at idle levels so the outputs are quiet until
            // the first decoded position has travelled through the line.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= IDLE;
                end else if (en) begin
                    dly_q[0] <= raw;
                    for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign dly_out = dly_q[PIPE_DELAY-1];
        end
    endgenerate

    assign x         = x_q;
    assign y         = y_q;
    assign frame_cnt = fc_q;
    assign active    = vis;
    // Gated by reset so the strobes stay low while the counters are forced to 0.
    assign line_start  = en && reset && (x_q == '0);
    assign frame_start = line_start && (y_q == '0);
    assign hsync   = dly_out[3];
    assign vsync   = dly_out[2];
    assign sync_b  = dly_out[1];
    assign blank_b = dly_out[0];

endmodule
